// File: rtl/csc_stream_pkg.sv
// ============================================================================
// Module   : csc_stream_pkg
// Brief    : Shared flag layout and round/saturate helper for CSC streams.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package csc_stream_pkg;

    localparam int MF_W = 4;
    localparam int SF_W = 2;

    localparam int MF_VALID = 0;
    localparam int MF_SOF   = 1;
    localparam int MF_EOL   = 2;
    localparam int MF_EOF   = 3;

    localparam int SF_STALL = 0;
    localparam int SF_ABORT = 1;

    // Framing bits {eof, eol, sof} carried alongside each channel sample.
    typedef logic [MF_W-1:1] frame_flags_t;

    // Round-half-up by 'frac' bits, then clamp to [0, 2^ow-1]. The caller
    // sign-extends its W-bit sample to 64 bits, which covers the W+1-bit sum.
    function automatic logic [31:0] round_sat(input logic signed [63:0] din,
                                              input int frac,
                                              input int ow);
        logic signed [63:0] v;
        logic signed [63:0] max_v;
        v = din;
        if (frac > 0) begin
            v = v + (64'sd1 <<< (frac - 1));
        end
        v     = v >>> frac;
        max_v = (64'sd1 <<< ow) - 64'sd1;
        if (v < 64'sd0) begin
            return 32'd0;
        end else if (v > max_v) begin
            return max_v[31:0];
        end else begin
            return v[31:0];
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/csc_chan_fifo2.sv
// ============================================================================
// Module   : csc_chan_fifo2
// Brief    : Two-entry channel FIFO with round/saturate applied on write.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csc_chan_fifo2
    import csc_stream_pkg::*;
#(
    parameter int W    = 16,
    parameter int OW   = 8,
    parameter int FRAC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_flush,
    input  logic [W-1:0]    i_din,
    input  logic [MF_W-1:0] i_din_mflags,
    input  logic            i_pop,
    output logic            o_full,
    output logic            o_not_empty,
    output logic [OW-1:0]   o_head_d,
    output frame_flags_t    o_head_flags
);

    logic [OW-1:0]  r_mem_d [2];
    frame_flags_t   r_mem_f [2];
    logic           r_wr_ptr;
    logic           r_rd_ptr;
    logic [1:0]     r_count;

    logic           w_push;
    logic           w_pop;
    logic [OW-1:0]  w_rs;
    logic [63:0]    w_din_sx;

    assign w_din_sx = {{(64 - W){i_din[W-1]}}, i_din};
    assign w_rs     = OW'(round_sat(w_din_sx, FRAC, OW));

    // Full is decoded purely from the count register so stall never depends
    // on this cycle's valid.
    assign o_full       = (r_count == 2'd2);
    assign o_not_empty  = (r_count != 2'd0);
    assign o_head_d     = r_mem_d[r_rd_ptr];
    assign o_head_flags = r_mem_f[r_rd_ptr];

    assign w_push = i_din_mflags[MF_VALID] && !o_full && !i_flush;
    assign w_pop  = i_pop && o_not_empty && !i_flush;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem_d[r_wr_ptr] <= w_rs;
                r_mem_f[r_wr_ptr] <= i_din_mflags[MF_W-1:1];
                r_wr_ptr          <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/csc_out_join.sv
// ============================================================================
// Module   : csc_out_join
// Brief    : Joins three rounded CSC channel streams into one packed pixel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module csc_out_join
    import csc_stream_pkg::*;
#(
    parameter int W    = 16,
    parameter int OW   = 8,
    parameter int FRAC = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [W-1:0]      c0,
    input  logic [W-1:0]      c1,
    input  logic [W-1:0]      c2,
    input  logic [MF_W-1:0]   c0_mflags,
    input  logic [MF_W-1:0]   c1_mflags,
    input  logic [MF_W-1:0]   c2_mflags,
    output logic [SF_W-1:0]   c0_sflags,
    output logic [SF_W-1:0]   c1_sflags,
    output logic [SF_W-1:0]   c2_sflags,
    output logic [3*OW-1:0]   out_d,
    output logic [MF_W-1:0]   out_mflags,
    input  logic [SF_W-1:0]   out_sflags,
    output logic              err_flag_mismatch
);

    logic [W-1:0]     w_c      [3];
    logic [MF_W-1:0]  w_cm     [3];
    logic [OW-1:0]    w_head_d [3];
    frame_flags_t     w_head_f [3];
    logic [2:0]       w_full;
    logic [2:0]       w_not_empty;
    logic [2:0]       w_stall;
    logic             w_abort;
    logic             w_pop_ok;
    logic             w_mismatch;

    logic [3*OW-1:0]  r_out_d;
    logic [MF_W-1:0]  r_out_mflags;
    logic             r_err;

    assign w_c[0]  = c0;
    assign w_c[1]  = c1;
    assign w_c[2]  = c2;
    assign w_cm[0] = c0_mflags;
    assign w_cm[1] = c1_mflags;
    assign w_cm[2] = c2_mflags;

    assign w_abort = out_sflags[SF_ABORT];

    generate
        for (genvar k = 0; k < 3; k++) begin : g_chan
            csc_chan_fifo2 #(
                .W    (W),
                .OW   (OW),
                .FRAC (FRAC)
            ) u_fifo (
                .clk          (clk),
                .rst          (rst),
                .i_flush      (w_abort),
                .i_din        (w_c[k]),
                .i_din_mflags (w_cm[k]),
                .i_pop        (w_pop_ok),
                .o_full       (w_full[k]),
                .o_not_empty  (w_not_empty[k]),
                .o_head_d     (w_head_d[k]),
                .o_head_flags (w_head_f[k])
            );
        end
    endgenerate

    // Abort and reset both mean "accept and discard", so stall is masked.
    assign w_stall   = w_full & {3{~w_abort & ~rst}};
    assign c0_sflags = {w_abort, w_stall[0]};
    assign c1_sflags = {w_abort, w_stall[1]};
    assign c2_sflags = {w_abort, w_stall[2]};

    assign w_pop_ok = (&w_not_empty) && !w_abort &&
                      (!r_out_mflags[MF_VALID] || !out_sflags[SF_STALL]);

    assign w_mismatch = (w_head_f[1] != w_head_f[0]) ||
                        (w_head_f[2] != w_head_f[0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_d      <= '0;
            r_out_mflags <= '0;
            r_err        <= 1'b0;
        end else if (w_abort) begin
            r_out_mflags <= '0;
        end else if (w_pop_ok) begin
            r_out_d      <= {w_head_d[2], w_head_d[1], w_head_d[0]};
            r_out_mflags <= {w_head_f[0], 1'b1};
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end else if (r_out_mflags[MF_VALID] && !out_sflags[SF_STALL]) begin
            r_out_mflags <= '0;
        end
    end

    assign out_d             = r_out_d;
    assign out_mflags        = r_out_mflags;
    assign err_flag_mismatch = r_err;

endmodule

`default_nettype wire
